// File: rtl/syscon_lock_monitor_pkg.sv
// syscon_lock_monitor_pkg: shared lock-monitor state encoding, parameter defaults and counter sizing
package syscon_lock_monitor_pkg;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LOCK_CYCLES = 1024;
  localparam int DEF_RESET_HOLD  = 16;
  localparam int DEF_CNT_W       = 8;
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_QUALIFY  = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RUN      = 2'd3
  } lock_state_e;
  function automatic int cnt_width(input int a, input int b);
    return $clog2(a > b ? a : b) + 1;
  endfunction
endpackage

// File: rtl/syscon_sync.sv
// syscon_sync: SYNC_STAGES-flop synchronizer for an asynchronous level input
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset, flops clear to 0
//   d_i    - asynchronous input
//   q_o    - synchronized output
module syscon_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/syscon_lock_monitor.sv
// syscon_lock_monitor: debounces PLL lock, sequences the fabric reset and logs loss-of-lock events
//   wb_clk       - system clock
//   wb_rst_n     - asynchronous active-low reset
//   pll_locked_i - raw lock, asynchronous to wb_clk
//   clear_i      - pulse clearing lock_lost and loss_count
//   locked       - qualified lock status
//   sys_rst      - active-high synchronous reset for the Wishbone domain
//   lock_lost    - sticky loss-of-lock flag
//   loss_count   - saturating count of loss events
module syscon_lock_monitor
  import syscon_lock_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int RESET_HOLD  = DEF_RESET_HOLD,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic             pll_locked_i,
  input  logic             clear_i,
  output logic             locked,
  output logic             sys_rst,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_count
);
  localparam int CW = cnt_width(LOCK_CYCLES, RESET_HOLD);
  localparam logic [CW-1:0] LC_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] RH_LAST = CW'(RESET_HOLD - 1);
  lock_state_e      state_q;
  logic [CW-1:0]    cnt_q;
  logic             locked_q, sys_rst_q, lost_q;
  logic [CNT_W-1:0] count_q;
  logic             s, loss;
  syscon_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i (wb_clk),
    .rst_ni(wb_rst_n),
    .d_i   (pll_locked_i),
    .q_o   (s)
  );
  // Dropping out of QUALIFY is only a failed qualification, not a loss.
  assign loss = !s && (state_q == ST_HOLD || state_q == ST_RUN);
  always_ff @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) begin
      state_q   <= ST_UNLOCKED;
      cnt_q     <= '0;
      locked_q  <= 1'b0;
      sys_rst_q <= 1'b1;
    end else begin
      case (state_q)
        ST_UNLOCKED:
          if (s) begin
            if (LOCK_CYCLES == 1) begin
              state_q  <= ST_HOLD;
              cnt_q    <= '0;
              locked_q <= 1'b1;
            end else begin
              state_q <= ST_QUALIFY;
              cnt_q   <= CW'(1);
            end
          end
        ST_QUALIFY:
          if (!s) begin
            state_q <= ST_UNLOCKED;
            cnt_q   <= '0;
          end else if (cnt_q == LC_LAST) begin
            state_q  <= ST_HOLD;
            cnt_q    <= '0;
            locked_q <= 1'b1;
          end else cnt_q <= cnt_q + CW'(1);
        ST_HOLD:
          if (!s) begin
            state_q  <= ST_UNLOCKED;
            cnt_q    <= '0;
            locked_q <= 1'b0;
          end else if (cnt_q == RH_LAST) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            sys_rst_q <= 1'b0;
          end else cnt_q <= cnt_q + CW'(1);
        default:
          if (!s) begin
            state_q   <= ST_UNLOCKED;
            locked_q  <= 1'b0;
            sys_rst_q <= 1'b1;
          end
      endcase
    end
  // A loss on the same edge as clear_i wins and starts the count afresh at 1.
  always_ff @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) begin
      lost_q  <= 1'b0;
      count_q <= '0;
    end else if (loss) begin
      lost_q  <= 1'b1;
      count_q <= clear_i ? CNT_W'(1) : (&count_q ? count_q : count_q + CNT_W'(1));
    end else if (clear_i) begin
      lost_q  <= 1'b0;
      count_q <= '0;
    end
  assign locked     = locked_q;
  assign sys_rst    = sys_rst_q;
  assign lock_lost  = lost_q;
  assign loss_count = count_q;
endmodule

// File: tb/tb_syscon_lock_monitor.sv
// tb_syscon_lock_monitor: randomized and directed checks of syscon_lock_monitor against a run-length model
module tb_syscon_lock_monitor;
  localparam int LC = 8;
  localparam int RH = 4;
  localparam int CW = 8;
  logic          wb_clk = 1'b0;
  logic          wb_rst_n = 1'b0;
  logic          pll_locked_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          locked, sys_rst, lock_lost;
  logic [CW-1:0] loss_count;
  int errors = 0;
  int checks = 0;
  int hist[$];
  int run, m_cnt, rise, fall;
  bit m_lost;
  syscon_lock_monitor #(
    .SYNC_STAGES(2), .LOCK_CYCLES(LC), .RESET_HOLD(RH), .CNT_W(CW)
  ) dut (
    .wb_clk      (wb_clk),
    .wb_rst_n    (wb_rst_n),
    .pll_locked_i(pll_locked_i),
    .clear_i     (clear_i),
    .locked      (locked),
    .sys_rst     (sys_rst),
    .lock_lost   (lock_lost),
    .loss_count  (loss_count)
  );
  always #5 wb_clk = ~wb_clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    hist = {0, 0};
    run = 0;
    m_cnt = 0;
    m_lost = 0;
  endtask
  // locked is "at least LC consecutive high samples of the synchronized lock";
  // sys_rst releases once that run reaches LC+RH.
  task automatic check_all(input string tag);
    check({tag, ".locked"}, 32'(locked), 32'(run >= LC));
    check({tag, ".sys_rst"}, 32'(sys_rst), 32'(run < LC + RH));
    check({tag, ".lock_lost"}, 32'(lock_lost), 32'(m_lost));
    check({tag, ".loss_count"}, 32'(loss_count), 32'(m_cnt));
  endtask
  task automatic tick(input bit p, input bit c, input string tag);
    bit s, loss;
    pll_locked_i = p;
    clear_i = c;
    @(posedge wb_clk);
    s = hist.pop_front() != 0;
    hist.push_back(int'(p));
    loss = !s && run >= LC;
    run = s ? (run < LC + RH ? run + 1 : run) : 0;
    if (c) begin
      m_cnt = 0;
      m_lost = 0;
    end
    if (loss) begin
      m_lost = 1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end
    #1 check_all(tag);
  endtask
  task automatic do_reset(input string tag);
    #2 wb_rst_n = 1'b0;
    model_reset();
    #1 check_all(tag);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
  endtask
  initial begin
    model_reset();
    pll_locked_i = 1'b1;
    repeat (3) @(posedge wb_clk);
    #1 check_all("in_reset");
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    rise = -1;
    fall = -1;
    for (int i = 1; i <= 16; i++) begin
      tick(1, 0, "s1_lock");
      if (locked && rise < 0) rise = i;
      if (!sys_rst && fall < 0) fall = i;
    end
    check("s1_lock_edge", 32'(rise), 32'd10);
    check("s1_rst_edge", 32'(fall), 32'd14);
    do_reset("s2_reset");
    repeat (5) tick(1, 0, "s2_pre");
    tick(0, 0, "s2_dip");
    rise = -1;
    for (int i = 1; i <= 14; i++) begin
      tick(1, 0, "s2_requal");
      if (locked && rise < 0) rise = i;
    end
    check("s2_lock_edge", 32'(rise), 32'd10);
    repeat (4) tick(0, 0, "s3_drop");
    check("s3_lost", 32'(lock_lost), 32'd1);
    check("s3_count", 32'(loss_count), 32'd1);
    repeat (14) tick(1, 0, "s3_relock");
    do_reset("s4_reset");
    repeat (9) tick(1, 0, "s4_hold");
    repeat (4) tick(0, 0, "s4_drop");
    check("s4_count", 32'(loss_count), 32'd1);
    repeat (260) begin
      repeat (9) tick(1, 0, "s5_cyc");
      tick(0, 0, "s5_loss");
    end
    check("s5_sat", 32'(loss_count), 32'hFF);
    tick(1, 1, "s5_clear");
    repeat (10) tick(1, 0, "s5_lock");
    tick(0, 0, "s5_fall");
    tick(0, 0, "s5_fall");
    tick(0, 1, "s5_clr_loss");
    check("s5_clr_loss_flag", 32'(lock_lost), 32'd1);
    check("s5_clr_loss_cnt", 32'(loss_count), 32'd1);
    repeat (60) begin
      int n;
      n = $urandom_range(1, 20);
      repeat (n) tick(1, $urandom_range(0, 15) == 0, "rnd_hi");
      n = $urandom_range(1, 3);
      repeat (n) tick(0, $urandom_range(0, 7) == 0, "rnd_lo");
    end
    repeat (15) tick(1, 0, "s7_run");
    do_reset("s7_async");
    repeat (3) tick(1, 0, "s7_after");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
